// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: ALU op classes, ID/EX control bundle and bubble constant.
// No logic; type/constant definitions only.
// No flow control.
package cpu_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_IMM   = 2'b11;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [5:0] funct;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        alu_op:     ALU_OP_ADD,
        funct:      6'd0,
        reg_dst:    1'b0,
        alu_src:    1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        reg_write:  1'b0
    };

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: a load in EX whose destination is a source of the ID instruction.
// Latency: purely combinational.
// No flow control; the result drives the stall decision in the ID/EX register.
module load_use_detect #(
    parameter int REG_W = cpu_pkg::DEF_REG_W
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_valid,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             hazard
);

    logic ex_is_load;
    logic rs_match;
    logic rt_match;

    always_comb begin
        // Loads to $0 never produce a value worth waiting for.
        ex_is_load = ex_valid & ex_mem_read & (ex_rt != '0);
        rs_match   = (ex_rt == id_rs);
        rt_match   = id_uses_rt & (ex_rt == id_rt);
        hazard     = ex_is_load & id_valid & (rs_match | rt_match);
    end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall, redirect flush and stall/flush counters.
// Latency: 1 cycle ID->EX; hazard/flush controls are combinational from EX state.
// Stall holds PC and IF/ID for one cycle and inserts a bubble; redirect wins over stall.
module id_ex_hazard_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic              id_uses_rt,
    input  logic [1:0]        id_alu_op,
    input  logic [5:0]        id_function,
    input  logic              id_reg_dst,
    input  logic              id_alu_src,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_reg_write,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              ex_redirect,
    output logic              ex_valid,
    output logic [1:0]        ex_alu_op,
    output logic [5:0]        ex_function,
    output logic              ex_reg_dst,
    output logic              ex_alu_src,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_reg_write,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic              pc_write_en,
    output logic              if_id_write_en,
    output logic              if_id_flush,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    ctrl_t             ctrl_in;
    logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              hazard;
    logic              take_bubble;

    load_use_detect #(.REG_W(REG_W)) u_detect (
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rt       (rt_q),
        .id_valid    (id_valid),
        .id_uses_rt  (id_uses_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .hazard      (hazard)
    );

    always_comb begin
        take_bubble = ex_redirect | hazard;

        ctrl_in = '{
            alu_op:     id_alu_op,
            funct:      id_function,
            reg_dst:    id_reg_dst,
            alu_src:    id_alu_src,
            mem_read:   id_mem_read,
            mem_write:  id_mem_write,
            mem_to_reg: id_mem_to_reg,
            reg_write:  id_reg_write
        };

        // An empty ID slot travels down the pipe as a bubble too.
        valid_d  = id_valid & ~take_bubble;
        ctrl_d   = valid_d ? ctrl_in : CTRL_NOP;
        rs_d     = id_rs;
        rt_d     = id_rt;
        rd_d     = id_rd;
        rdata1_d = id_rdata1;
        rdata2_d = id_rdata2;
        imm_d    = id_imm;

        stall_cnt_d = stall_cnt_q;
        if (hazard && !ex_redirect && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (ex_redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end

        pc_write_en    = ex_redirect | ~hazard;
        if_id_write_en = ex_redirect | ~hazard;
        if_id_flush    = ex_redirect;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= 1'b0;
            ctrl_q      <= CTRL_NOP;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            imm_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
            imm_q       <= imm_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_function   = ctrl_q.funct;
    assign ex_reg_dst    = ctrl_q.reg_dst;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_rd         = rd_q;
    assign ex_rdata1     = rdata1_q;
    assign ex_rdata2     = rdata2_q;
    assign ex_imm        = imm_q;
    assign stall_count   = stall_cnt_q;
    assign flush_count   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg: reset, load-use stalls, $0 exemption, redirect, saturation.
module tb_id_ex_hazard_reg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              id_valid, id_uses_rt;
    logic [1:0]        id_alu_op;
    logic [5:0]        id_function;
    logic              id_reg_dst, id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write;
    logic [REG_W-1:0]  id_rs, id_rt, id_rd;
    logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm;
    logic              ex_redirect;
    logic              ex_valid;
    logic [1:0]        ex_alu_op;
    logic [5:0]        ex_function;
    logic              ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
    logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;
    logic [DATA_W-1:0] ex_rdata1, ex_rdata2, ex_imm;
    logic              pc_write_en, if_id_write_en, if_id_flush;
    logic [CNT_W-1:0]  stall_count, flush_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_hazard_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_uses_rt(id_uses_rt),
        .id_alu_op(id_alu_op), .id_function(id_function),
        .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .ex_redirect(ex_redirect),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_function(ex_function),
        .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .if_id_flush(if_id_flush),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    typedef struct {
        logic       vld, uses_rt, mr, rw, redir;
        logic [4:0] rs, rt;
        logic [1:0] alu;
        logic [5:0] fn;
        logic       e_pcw, e_ifw, e_fl;
        logic       e_vld, e_mr, e_rw;
        logic [1:0] e_alu;
        logic [5:0] e_fn;
        logic [4:0] e_rt;
        logic [3:0] e_stall, e_flush;
    } vec_t;

    vec_t vec[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_all_ones();
        id_valid = 1'b1; id_uses_rt = 1'b1; id_alu_op = 2'b11; id_function = 6'h3F;
        id_reg_dst = 1'b1; id_alu_src = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b1;
        id_mem_to_reg = 1'b1; id_reg_write = 1'b1;
        id_rs = 5'h1F; id_rt = 5'h1E; id_rd = 5'h1D;
        id_rdata1 = 32'hDEAD_BEEF; id_rdata2 = 32'h1234_5678; id_imm = 32'hFFFF_FFF0;
        ex_redirect = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v, input int i);
        id_valid = v.vld; id_uses_rt = v.uses_rt; id_alu_op = v.alu; id_function = v.fn;
        id_reg_dst = (v.alu == 2'b10); id_alu_src = v.mr; id_mem_read = v.mr;
        id_mem_write = 1'b0; id_mem_to_reg = v.mr; id_reg_write = v.rw;
        id_rs = v.rs; id_rt = v.rt; id_rd = v.rs ^ v.rt;
        id_rdata1 = 32'hA500_0000 + 32'(i); id_rdata2 = ~(32'hA500_0000 + 32'(i));
        id_imm = 32'(i) << 4;
        ex_redirect = v.redir;
    endtask

    initial begin
        // in: vld ur mr rw rd  rs rt alu fn | exp: pcw ifw fl vld mr rw alu fn rt stall flush
        vec[0]  = '{1'b1,1'b0,1'b1,1'b1,1'b0, 5'd1, 5'd8, 2'b00,6'h00, 1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1,2'b00,6'h00,5'd8, 4'd0,4'd0};
        vec[1]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 5'd8, 5'd2, 2'b10,6'h20, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,2'b00,6'h00,5'd2, 4'd1,4'd0};
        vec[2]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 5'd8, 5'd2, 2'b10,6'h20, 1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,2'b10,6'h20,5'd2, 4'd1,4'd0};
        vec[3]  = '{1'b1,1'b0,1'b1,1'b1,1'b0, 5'd4, 5'd9, 2'b00,6'h00, 1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1,2'b00,6'h00,5'd9, 4'd1,4'd0};
        vec[4]  = '{1'b1,1'b0,1'b1,1'b1,1'b0, 5'd5, 5'd9, 2'b00,6'h00, 1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1,2'b00,6'h00,5'd9, 4'd1,4'd0};
        vec[5]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 5'd6, 5'd9, 2'b10,6'h22, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,2'b00,6'h00,5'd9, 4'd2,4'd0};
        vec[6]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 5'd6, 5'd9, 2'b10,6'h22, 1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,2'b10,6'h22,5'd9, 4'd2,4'd0};
        vec[7]  = '{1'b1,1'b0,1'b1,1'b1,1'b0, 5'd1, 5'd0, 2'b00,6'h00, 1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1,2'b00,6'h00,5'd0, 4'd2,4'd0};
        vec[8]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 5'd0, 5'd0, 2'b10,6'h20, 1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,2'b10,6'h20,5'd0, 4'd2,4'd0};
        vec[9]  = '{1'b1,1'b0,1'b1,1'b1,1'b0, 5'd1, 5'd7, 2'b00,6'h00, 1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1,2'b00,6'h00,5'd7, 4'd2,4'd0};
        vec[10] = '{1'b1,1'b0,1'b1,1'b1,1'b0, 5'd7, 5'd10,2'b00,6'h00, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,2'b00,6'h00,5'd10,4'd3,4'd0};
        vec[11] = '{1'b1,1'b0,1'b1,1'b1,1'b0, 5'd7, 5'd10,2'b00,6'h00, 1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1,2'b00,6'h00,5'd10,4'd3,4'd0};
        vec[12] = '{1'b1,1'b1,1'b0,1'b1,1'b1, 5'd10,5'd1, 2'b10,6'h20, 1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,2'b00,6'h00,5'd1, 4'd3,4'd1};
        vec[13] = '{1'b0,1'b1,1'b1,1'b1,1'b0, 5'd3, 5'd4, 2'b11,6'h3F, 1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,2'b00,6'h00,5'd4, 4'd3,4'd1};
        vec[14] = '{1'b1,1'b0,1'b0,1'b1,1'b1, 5'd2, 5'd5, 2'b11,6'h00, 1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,2'b00,6'h00,5'd5, 4'd3,4'd2};

        // Reset held with every ID field nonzero.
        reset_n = 1'b0;
        drive_all_ones();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ex_ctrl", {62'd0, ex_valid, ex_reg_write},  64'd0);
        chk("reset_ex_bus",  {ex_alu_op, ex_function, ex_reg_dst, ex_alu_src, ex_mem_read,
                              ex_mem_write, ex_mem_to_reg, ex_rs, ex_rt, ex_rd}, 64'd0);
        chk("reset_ex_data", {ex_rdata1, ex_rdata2}, 64'd0);
        chk("reset_imm",     ex_imm, 64'd0);
        chk("reset_counts",  {stall_count, flush_count}, 64'd0);
        chk("reset_pc_wen",  {pc_write_en, if_id_write_en, if_id_flush}, 64'b110);

        // First edge after release captures the ID fields.
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_ctrl", {ex_valid, ex_alu_op, ex_function, ex_reg_dst, ex_alu_src, ex_mem_read,
                             ex_mem_write, ex_mem_to_reg, ex_reg_write}, {1'b1, 2'b11, 6'h3F, 6'b111111});
        chk("release_regs", {ex_rs, ex_rt, ex_rd}, {5'h1F, 5'h1E, 5'h1D});
        chk("release_data", {ex_rdata1, ex_rdata2}, {32'hDEAD_BEEF, 32'h1234_5678});

        // Load in EX to $30 and ID reads $30: stall asserted, then async reset mid-stall.
        chk("pre_reset_stall", {pc_write_en, if_id_write_en}, 64'b00);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midstall_reset_ex", {ex_valid, ex_mem_read}, 64'b00);
        chk("midstall_reset_wen", {pc_write_en, if_id_write_en, if_id_flush}, 64'b110);
        chk("midstall_reset_cnt", stall_count, 64'd0);

        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive_vec(vec[i], i);
            #1;
            chk($sformatf("v%0d_hazard_ctl", i), {pc_write_en, if_id_write_en, if_id_flush},
                {vec[i].e_pcw, vec[i].e_ifw, vec[i].e_fl});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ex_ctrl", i),
                {ex_valid, ex_mem_read, ex_reg_write, ex_alu_op, ex_function, ex_mem_to_reg, ex_alu_src, ex_reg_dst},
                {vec[i].e_vld, vec[i].e_mr, vec[i].e_rw, vec[i].e_alu, vec[i].e_fn, vec[i].e_mr, vec[i].e_mr,
                 (vec[i].e_alu == 2'b10)});
            chk($sformatf("v%0d_ex_regs", i), {ex_rs, ex_rt, ex_rd},
                {vec[i].rs, vec[i].e_rt, vec[i].rs ^ vec[i].rt});
            chk($sformatf("v%0d_ex_data", i), {ex_rdata1, ex_imm},
                {32'hA500_0000 + 32'(i), 32'(i) << 4});
            chk($sformatf("v%0d_counts", i), {stall_count, flush_count}, {vec[i].e_stall, vec[i].e_flush});
            @(negedge clk);
        end

        // Dependent load chain: stalls every other cycle, pushing stall_count past saturation.
        drive_vec('{1'b1,1'b0,1'b1,1'b1,1'b0, 5'd7, 5'd7, 2'b00,6'h00, 1'b1,1'b1,1'b0,
                    1'b1,1'b1,1'b1,2'b00,6'h00,5'd7, 4'd0,4'd0}, 20);
        repeat (24) @(posedge clk);
        #1;
        chk("sat_reach", stall_count, 64'hF);
        repeat (14) @(posedge clk);
        #1;
        chk("sat_hold", stall_count, 64'hF);
        chk("sat_flush_unchanged", flush_count, 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
